waveform_source: RTL and testbench

- Parametrised test-waveform generator for the DSP TX path; successor to the fixed constant-waveform source.
- Produces one WIDTH-bit sample per pop, in one of three modes: constant, ramp or table playback.
- Framed output: start-of-frame and end-of-frame flags over a programmable frame length.
- Configured over the settings bus; feeds the TX pop interface (data, flags, pop_en/pop_rdy).

---
 rtl/waveform_source.sv | 207 ++++++++++++++++++++
 tb/tb_waveform_source.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/waveform_source.sv
// waveform_source
//   Test-waveform generator for the DSP TX path. Emits one WIDTH-bit sample
//   per pop in constant, ramp or table-playback mode, framed with
//   start/end-of-frame flags over a programmable frame length. Configured
//   through the settings bus at BASE..BASE+6.
//
// Ports
//   dsp_clk     : sole clock
//   dsp_rst_n   : asynchronous active-low reset
//   set_stb     : settings write strobe
//   set_addr    : settings address
//   set_data    : settings write data
//   tx_data     : current sample (valid while tx_pop_rdy)
//   tx_flags    : {2'b0, eof, sof} of the current sample
//   tx_pop_en   : consumer takes the current sample this cycle
//   tx_pop_rdy  : current sample valid
//   debug       : {mode, enable, sof, eof, rdy, pop_en, 9'b0, frame_cnt[15:0]}
module waveform_source #(
  parameter int WIDTH = 32,
  parameter int BASE  = 128,
  parameter int DEPTH = 16,
  parameter int LEN_W = 13
) (
  input  logic             dsp_clk,
  input  logic             dsp_rst_n,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  output logic [WIDTH-1:0] tx_data,
  output logic [3:0]       tx_flags,
  input  logic             tx_pop_en,
  output logic             tx_pop_rdy,
  output logic [31:0]      debug
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [7:0] ADDR_CTRL  = 8'(BASE);
  localparam logic [7:0] ADDR_VALUE = 8'(BASE + 1);
  localparam logic [7:0] ADDR_STEP  = 8'(BASE + 2);
  localparam logic [7:0] ADDR_FLEN  = 8'(BASE + 3);
  localparam logic [7:0] ADDR_TADDR = 8'(BASE + 4);
  localparam logic [7:0] ADDR_TDATA = 8'(BASE + 5);
  localparam logic [7:0] ADDR_TLEN  = 8'(BASE + 6);

  localparam logic [31:0] DEPTH32  = 32'(DEPTH);
  localparam logic [AW:0] TLEN_MAX = (AW + 1)'(DEPTH);

  typedef enum logic {S_IDLE, S_RUN} state_t;
  typedef enum logic [1:0] {M_CONST, M_RAMP, M_TABLE, M_RSVD} mode_t;

  // Index of the last sample in a frame; a programmed length of 0 acts as 1.
  function automatic logic [LEN_W-1:0] flenLast(input logic [LEN_W-1:0] flen);
    return (flen == '0) ? '0 : flen - LEN_W'(1);
  endfunction

  state_t            state_q, state_d;
  mode_t             mode_q, mode_d;
  logic [WIDTH-1:0]  value_q, value_d;
  logic [WIDTH-1:0]  step_q, step_d;
  logic [LEN_W-1:0]  flen_q, flen_d;
  logic [AW-1:0]     taddr_q, taddr_d;
  logic [AW:0]       tlen_q, tlen_d;
  logic [LEN_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [WIDTH-1:0]  table_q [DEPTH];

  logic [WIDTH-1:0]  tx_data_q;
  logic [3:0]        tx_flags_q;
  logic              tx_pop_rdy_q;
  logic [31:0]       debug_q;

  logic [WIDTH-1:0]  wdata;
  logic              pop;
  logic              ctrl_wr;
  logic              tbl_we;
  logic              eof_now;
  logic              idx_last;
  logic              run_d;
  logic              sof_d;
  logic              eof_d;
  logic [WIDTH-1:0]  tbl_rd;
  logic [WIDTH-1:0]  sample_d;

  assign wdata    = WIDTH'(set_data);
  assign pop      = tx_pop_en && (state_q == S_RUN);
  // Wrap decisions belong to the sample being popped, so they use the
  // settings that were in force when that sample was registered.
  assign eof_now  = (frame_cnt_q >= flenLast(flen_q));
  assign idx_last = ({1'b0, idx_q} == (tlen_q - (AW + 1)'(1)));

  // Settings decode and generator advance. A CTRL write restarts the
  // generator and takes priority over a pop in the same cycle.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    value_d     = value_q;
    step_d      = step_q;
    flen_d      = flen_q;
    taddr_d     = taddr_q;
    tlen_d      = tlen_q;
    frame_cnt_d = frame_cnt_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    ctrl_wr     = 1'b0;
    tbl_we      = 1'b0;

    if (set_stb) begin
      case (set_addr)
        ADDR_CTRL: begin
          ctrl_wr = 1'b1;
          state_d = set_data[0] ? S_RUN : S_IDLE;
          mode_d  = mode_t'(set_data[2:1]);
        end
        ADDR_VALUE: value_d = wdata;
        ADDR_STEP:  step_d  = wdata;
        ADDR_FLEN:  flen_d  = set_data[LEN_W-1:0];
        ADDR_TADDR: taddr_d = set_data[AW-1:0];
        ADDR_TDATA: begin
          tbl_we  = 1'b1;
          taddr_d = taddr_q + AW'(1);
        end
        ADDR_TLEN: begin
          tlen_d = ((set_data == '0) || (set_data > DEPTH32)) ? TLEN_MAX
                                                             : set_data[AW:0];
        end
        default: ;
      endcase
    end

    if (ctrl_wr) begin
      frame_cnt_d = '0;
      acc_d       = value_q;
      idx_d       = '0;
    end else if (pop) begin
      frame_cnt_d = eof_now ? '0 : frame_cnt_q + LEN_W'(1);
      acc_d       = acc_q + step_d;
      idx_d       = idx_last ? '0 : idx_q + AW'(1);
    end
  end

  // Next registered sample. Everything is derived from next-state values so
  // that settings writes (VALUE, TDATA on the playing index, FLEN) show up
  // on the output the cycle after the write.
  always_comb begin
    run_d  = (state_d == S_RUN);
    sof_d  = (frame_cnt_d == '0);
    eof_d  = (frame_cnt_d >= flenLast(flen_d));
    tbl_rd = (tbl_we && (taddr_q == idx_d)) ? wdata : table_q[idx_d];
    case (mode_d)
      M_CONST: sample_d = value_d;
      M_RAMP:  sample_d = acc_d;
      M_TABLE: sample_d = tbl_rd;
      default: sample_d = '0;
    endcase
  end

  // Control state, settings registers and registered outputs.
  always_ff @(posedge dsp_clk or negedge dsp_rst_n) begin
    if (!dsp_rst_n) begin
      state_q      <= S_IDLE;
      mode_q       <= M_CONST;
      value_q      <= '0;
      step_q       <= WIDTH'(1);
      flen_q       <= LEN_W'(1);
      taddr_q      <= '0;
      tlen_q       <= TLEN_MAX;
      frame_cnt_q  <= '0;
      acc_q        <= '0;
      idx_q        <= '0;
      tx_data_q    <= '0;
      tx_flags_q   <= '0;
      tx_pop_rdy_q <= 1'b0;
      debug_q      <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      value_q      <= value_d;
      step_q       <= step_d;
      flen_q       <= flen_d;
      taddr_q      <= taddr_d;
      tlen_q       <= tlen_d;
      frame_cnt_q  <= frame_cnt_d;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      tx_pop_rdy_q <= run_d;
      tx_data_q    <= run_d ? sample_d : '0;
      tx_flags_q   <= run_d ? {2'b00, eof_d, sof_d} : 4'b0000;
      debug_q      <= {mode_d, run_d, run_d & sof_d, run_d & eof_d, run_d,
                       tx_pop_en, 9'b0, 16'(frame_cnt_d)};
    end
  end

  // Pattern table: plain storage, contents undefined after reset.
  always_ff @(posedge dsp_clk) begin
    if (tbl_we) begin
      table_q[taddr_q] <= wdata;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_flags   = tx_flags_q;
  assign tx_pop_rdy = tx_pop_rdy_q;
  assign debug      = debug_q;

endmodule

// File: tb/tb_waveform_source.sv
// tb_waveform_source
//   Directed test-plan sequence followed by a randomized phase, all checked
//   against a behavioural model of the waveform source.
module tb_waveform_source;

  localparam int WIDTH = 32;
  localparam int BASE  = 128;
  localparam int DEPTH = 16;
  localparam int LEN_W = 13;

  localparam int R_CTRL  = 0;
  localparam int R_VALUE = 1;
  localparam int R_STEP  = 2;
  localparam int R_FLEN  = 3;
  localparam int R_TADDR = 4;
  localparam int R_TDATA = 5;
  localparam int R_TLEN  = 6;

  logic             dsp_clk = 1'b0;
  logic             dsp_rst_n = 1'b0;
  logic             set_stb = 1'b0;
  logic [7:0]       set_addr = '0;
  logic [31:0]      set_data = '0;
  logic             tx_pop_en = 1'b0;
  logic [WIDTH-1:0] tx_data;
  logic [3:0]       tx_flags;
  logic             tx_pop_rdy;
  logic [31:0]      debug;

  int compared = 0;
  int mismatched = 0;

  // Behavioural model: configuration, stream position and table image.
  bit              mRun;
  int              mMode;
  longint unsigned mValue, mStep, mAcc;
  int              mFlen, mTlen, mPos, mIdx, mTaddr;
  longint unsigned mTable [DEPTH];

  waveform_source #(
    .WIDTH(WIDTH), .BASE(BASE), .DEPTH(DEPTH), .LEN_W(LEN_W)
  ) dut (
    .dsp_clk    (dsp_clk),
    .dsp_rst_n  (dsp_rst_n),
    .set_stb    (set_stb),
    .set_addr   (set_addr),
    .set_data   (set_data),
    .tx_data    (tx_data),
    .tx_flags   (tx_flags),
    .tx_pop_en  (tx_pop_en),
    .tx_pop_rdy (tx_pop_rdy),
    .debug      (debug)
  );

  always #5 dsp_clk = ~dsp_clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic modelReset();
    mRun = 0; mMode = 0; mValue = 0; mStep = 1; mAcc = 0;
    mFlen = 1; mTlen = DEPTH; mPos = 0; mIdx = 0; mTaddr = 0;
  endtask

  function automatic int effFlen();
    return (mFlen == 0) ? 1 : mFlen;
  endfunction

  // One clock edge of the model, mirroring the documented rules.
  task automatic modelStep(input logic stb, input logic [7:0] addr,
                           input logic [31:0] data, input logic pop);
    bit popOk, eofNow, lastIdx, ctrlWr;
    int off;
    popOk   = pop && mRun;
    eofNow  = (mPos >= effFlen() - 1);
    lastIdx = (mIdx == mTlen - 1);
    ctrlWr  = 0;
    off     = int'(addr) - BASE;
    if (stb) begin
      case (off)
        R_CTRL:  begin ctrlWr = 1; mRun = data[0]; mMode = int'(data[2:1]); end
        R_VALUE: mValue = data;
        R_STEP:  mStep = data;
        R_FLEN:  mFlen = int'(data % (1 << LEN_W));
        R_TADDR: mTaddr = int'(data % DEPTH);
        R_TDATA: begin mTable[mTaddr] = data; mTaddr = (mTaddr + 1) % DEPTH; end
        R_TLEN:  mTlen = (data == 0 || data > DEPTH) ? DEPTH : int'(data);
        default: ;
      endcase
    end
    if (ctrlWr) begin
      mPos = 0; mAcc = mValue; mIdx = 0;
    end else if (popOk) begin
      mPos = eofNow ? 0 : mPos + 1;
      mAcc = (mAcc + mStep) % 64'h1_0000_0000;
      mIdx = lastIdx ? 0 : (mIdx + 1) % DEPTH;
    end
  endtask

  function automatic logic [31:0] expData();
    case (mMode)
      0:       return mValue[31:0];
      1:       return mAcc[31:0];
      2:       return mTable[mIdx][31:0];
      default: return 32'h0;
    endcase
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, "_rdy"}, 32'(tx_pop_rdy), 32'(mRun));
    if (mRun) begin
      checkVal({tag, "_data"}, tx_data, expData());
      checkVal({tag, "_flags"}, 32'(tx_flags),
               {28'b0, 2'b00, 1'(mPos >= effFlen() - 1), 1'(mPos == 0)});
      checkVal({tag, "_dbgcnt"}, 32'(debug[15:0]), 32'(mPos));
      checkVal({tag, "_dbgmode"}, 32'(debug[31:29]), {29'b0, 2'(mMode), 1'b1});
    end
  endtask

  // Drive one cycle's inputs, advance DUT and model together, sample #1 later.
  task automatic applyStimulus(input logic stb, input logic [7:0] addr,
                               input logic [31:0] data, input logic pop);
    set_stb = stb; set_addr = addr; set_data = data; tx_pop_en = pop;
    @(posedge dsp_clk);
    modelStep(stb, addr, data, pop);
    #1;
    set_stb = 1'b0; tx_pop_en = 1'b0;
  endtask

  task automatic wrReg(input int off, input logic [31:0] d);
    applyStimulus(1'b1, 8'(BASE + off), d, 1'b0);
    checkOutput("wr");
  endtask

  task automatic popOnce(input string tag);
    applyStimulus(1'b0, 8'h00, 32'h0, 1'b1);
    checkOutput(tag);
  endtask

  initial begin
    logic [31:0] rampExp [4];
    logic [31:0] tblExp [5];
    logic [31:0] holdData;
    rampExp = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1};
    tblExp  = '{32'd10, 32'd20, 32'd30, 32'd10, 32'd20};
    modelReset();

    // Reset values
    #12;
    checkVal("rst_rdy", 32'(tx_pop_rdy), 32'h0);
    checkVal("rst_data", tx_data, 32'h0);
    checkVal("rst_flags", 32'(tx_flags), 32'h0);
    checkVal("rst_debug", debug, 32'h0);
    dsp_rst_n = 1'b1;

    // 1: constant mode with 4-sample frames
    $display("[TB] constant mode");
    wrReg(R_VALUE, 32'hDEADBEEF);
    wrReg(R_FLEN, 32'd4);
    wrReg(R_CTRL, 32'h1);
    checkVal("t1_rdy", 32'(tx_pop_rdy), 32'h1);
    for (int i = 0; i < 8; i++) begin
      checkVal("t1_data", tx_data, 32'hDEADBEEF);
      checkVal("t1_sof", 32'(tx_flags[0]), 32'((i % 4) == 0));
      checkVal("t1_eof", 32'(tx_flags[1]), 32'((i % 4) == 3));
      popOnce("t1_pop");
    end

    // 2: ramp wrapping through zero, with idle hold
    $display("[TB] ramp mode");
    wrReg(R_VALUE, 32'hFFFFFFFE);
    wrReg(R_STEP, 32'h1);
    wrReg(R_CTRL, 32'h3);
    for (int i = 0; i < 4; i++) begin
      checkVal("t2_data", tx_data, rampExp[i]);
      if (i == 2) begin
        for (int k = 0; k < 3; k++) begin
          applyStimulus(1'b0, 8'h00, 32'h0, 1'b0);
          checkVal("t2_hold", tx_data, rampExp[i]);
        end
      end
      popOnce("t2_pop");
    end

    // 3: table playback, then disable
    $display("[TB] table mode");
    wrReg(R_TADDR, 32'd0);
    wrReg(R_TDATA, 32'd10);
    wrReg(R_TDATA, 32'd20);
    wrReg(R_TDATA, 32'd30);
    wrReg(R_TLEN, 32'd3);
    wrReg(R_CTRL, 32'h5);
    for (int i = 0; i < 5; i++) begin
      checkVal("t3_data", tx_data, tblExp[i]);
      popOnce("t3_pop");
    end
    wrReg(R_CTRL, 32'h0);
    checkVal("t3_off", 32'(tx_pop_rdy), 32'h0);
    for (int i = 0; i < 3; i++) popOnce("t3_ignored");
    wrReg(R_CTRL, 32'h5);
    checkVal("t3_restart", tx_data, 32'd10);

    // 4: CTRL rewrite colliding with a pop
    $display("[TB] restart vs pop");
    wrReg(R_VALUE, 32'd100);
    wrReg(R_STEP, 32'd7);
    wrReg(R_CTRL, 32'h3);
    for (int i = 0; i < 3; i++) popOnce("t4_pop");
    checkVal("t4_pre", tx_data, 32'd121);
    applyStimulus(1'b1, 8'(BASE + R_CTRL), 32'h3, 1'b1);
    checkOutput("t4_restart");
    checkVal("t4_data", tx_data, 32'd100);
    checkVal("t4_sof", 32'(tx_flags[0]), 32'h1);
    checkVal("t4_cnt", 32'(debug[15:0]), 32'h0);

    // 5: degenerate and shrinking frame lengths
    $display("[TB] framing edge cases");
    wrReg(R_FLEN, 32'd0);
    for (int i = 0; i < 4; i++) begin
      checkVal("t5_len1", 32'(tx_flags), 32'h3);
      popOnce("t5_pop");
    end
    wrReg(R_FLEN, 32'd8);
    wrReg(R_CTRL, 32'h3);
    for (int i = 0; i < 5; i++) popOnce("t5_pop8");
    checkVal("t5_mid", 32'(tx_flags), 32'h0);
    checkVal("t5_cnt5", 32'(debug[15:0]), 32'd5);
    wrReg(R_FLEN, 32'd3);
    checkVal("t5_eof", 32'(tx_flags), 32'h2);
    popOnce("t5_wrap");
    checkVal("t5_sof", 32'(tx_flags), 32'h1);

    // 6: asynchronous reset mid-frame
    $display("[TB] async reset");
    popOnce("t6_pop");
    holdData = tx_data;
    checkVal("t6_live", 32'(tx_pop_rdy), 32'h1);
    #3;
    dsp_rst_n = 1'b0;
    #1;
    checkVal("t6_rdy", 32'(tx_pop_rdy), 32'h0);
    checkVal("t6_data", tx_data, 32'h0);
    checkVal("t6_flags", 32'(tx_flags), 32'h0);
    #2;
    dsp_rst_n = 1'b1;
    modelReset();
    for (int i = 0; i < 3; i++) begin
      popOnce("t6_after");
      checkVal("t6_idle", 32'(tx_pop_rdy), 32'h0);
    end
    if (holdData == 32'h0) $display("[TB] note: sample before reset was zero");

    // Randomized phase: fill the table, then mix writes and pops
    $display("[TB] random phase");
    wrReg(R_TADDR, 32'd0);
    for (int i = 0; i < DEPTH; i++) wrReg(R_TDATA, $urandom);
    wrReg(R_CTRL, 32'h1);
    for (int n = 0; n < 500; n++) begin
      logic        stb;
      logic [7:0]  addr;
      logic [31:0] data;
      int          off;
      stb  = ($urandom_range(0, 9) < 3);
      off  = $urandom_range(0, 8);
      addr = 8'(BASE + off);
      case (off)
        R_CTRL:  data = {29'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0)};
        R_FLEN:  data = $urandom_range(0, 6);
        R_TADDR: data = $urandom_range(0, 20);
        R_TLEN:  data = $urandom_range(0, 20);
        default: data = $urandom;
      endcase
      if ($urandom_range(0, 19) == 0) addr = 8'h10;
      applyStimulus(stb, addr, data, 1'($urandom_range(0, 9) < 7));
      checkOutput("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
